// File: rtl/idu_ctrl_pkg.sv
// Shared types for the instruction decode stage: immediate formats,
// RV32 opcode constants and FSM state encodings.
package idu_ctrl_pkg;

  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_U = 3'd1,
    FMT_J = 3'd2,
    FMT_S = 3'd3,
    FMT_B = 3'd4
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/idu_ctrl_decode_imm.sv
// Purely combinational RV32 immediate extraction for a given format.
module decodeIMM
  import idu_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  input  fmt_e        fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = {{20{inst[31]}}, inst[31:20]};
    case (fmt)
      FMT_U: imm = {inst[31:12], 12'b0};
      FMT_J: imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      FMT_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B: imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      default: imm = {{20{inst[31]}}, inst[31:20]};
    endcase
  end

endmodule

// File: rtl/idu_ctrl.sv
// Decode stage: one-entry skid-free pipeline register with immediate decode,
// illegal-opcode halt, flush and a consumed-result counter.
module idu_ctrl
  import idu_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_imm,
  output logic [2:0]       out_op_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] dec_cnt
);

  state_e           state_reg;
  logic [31:0]      inst_reg;
  logic [31:0]      pc_reg;
  logic [31:0]      imm_reg;
  fmt_e             fmt_reg;
  logic             illegal_reg;
  logic [CNT_W-1:0] cnt_reg;

  fmt_e        fmt_next;
  logic        illegal_next;
  logic [31:0] imm_next;
  logic        accept;
  logic        consume;

  always_comb begin
    fmt_next     = FMT_I;
    illegal_next = 1'b0;
    case (in_inst[6:0])
      OP_LUI, OP_AUIPC: fmt_next = FMT_U;
      OP_JAL:           fmt_next = FMT_J;
      OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM, OP_REG: fmt_next = FMT_I;
      OP_STORE:         fmt_next = FMT_S;
      OP_BRANCH:        fmt_next = FMT_B;
      default:          illegal_next = 1'b1;
    endcase
  end

  decodeIMM u_decode_imm (
    .inst (in_inst),
    .fmt  (fmt_next),
    .imm  (imm_next)
  );

  // Consuming an illegal result sends us to HALT, so no accept can overlap it.
  assign in_ready = !flush && ((state_reg == ST_EMPTY) ||
                    (state_reg == ST_FULL && out_ready && !illegal_reg));
  assign accept   = in_valid && in_ready;
  assign consume  = (state_reg == ST_FULL) && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_EMPTY;
      inst_reg    <= '0;
      pc_reg      <= '0;
      imm_reg     <= '0;
      fmt_reg     <= FMT_I;
      illegal_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      if (consume)
        cnt_reg <= cnt_reg + CNT_W'(1);
      if (accept) begin
        inst_reg    <= in_inst;
        pc_reg      <= in_pc;
        imm_reg     <= imm_next;
        fmt_reg     <= fmt_next;
        illegal_reg <= illegal_next;
      end
      if (flush) begin
        state_reg <= ST_EMPTY;
      end else begin
        case (state_reg)
          ST_EMPTY: if (accept) state_reg <= ST_FULL;
          ST_FULL: begin
            if (out_ready) begin
              if (illegal_reg)  state_reg <= ST_HALT;
              else if (accept)  state_reg <= ST_FULL;
              else              state_reg <= ST_EMPTY;
            end
          end
          ST_HALT:  state_reg <= ST_HALT;
          default:  state_reg <= ST_EMPTY;
        endcase
      end
    end
  end

  assign out_valid   = (state_reg == ST_FULL);
  assign out_inst    = inst_reg;
  assign out_pc      = pc_reg;
  assign out_imm     = imm_reg;
  assign out_op_imm  = fmt_reg;
  assign out_illegal = illegal_reg;
  assign dec_cnt     = cnt_reg;

endmodule

// File: doc/idu_ctrl.md
IDU_CTRL -- requirements
Module: idu_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the decoded-instruction counter.
REQ-002 SHALL have port clk  input  1  system clock, rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  fetch stage offers an instruction.
REQ-005 SHALL have port in_ready  output  1  block accepts the offered instruction.
REQ-006 SHALL have port in_inst  input  32  raw RV32 instruction word.
REQ-007 SHALL have port in_pc  input  32  PC of in_inst.
REQ-008 SHALL have port flush  input  1  discard held result and leave HALT.
REQ-009 SHALL have port out_valid  output  1  decoded result is held for the execute stage.
REQ-010 SHALL have port out_ready  input  1  execute stage consumes the result.
REQ-011 SHALL have port out_inst, out_pc  output  32 each  registered copies of in_inst and in_pc.
REQ-012 SHALL have port out_imm  output  32  registered immediate.
REQ-013 SHALL have port out_op_imm  output  3  registered immediate-format select.
REQ-014 SHALL have port out_illegal  output  1  registered flag for an unrecognised opcode.
REQ-015 SHALL have port dec_cnt  output  CNT_W  count of results consumed.

Function
REQ-016 SHALL map opcode inst[6:0] to a format: 0110111/0010111 U; 1101111 J; 1100111/0000011/0010011/1110011/0110011 I; 0100011 S; 1100011 B; any other opcode I with illegal=1.
REQ-017 SHALL compute out_imm from in_inst and the selected format using decodeIMM, and register it together with out_op_imm, out_inst, out_pc and out_illegal.
REQ-018 SHALL implement a state machine with states EMPTY, FULL and HALT, where out_valid=1 only in FULL.
REQ-019 SHALL drive in_ready = (EMPTY) or (FULL and out_ready); in_ready SHALL be 0 in HALT.
REQ-020 SHALL accept an instruction (in_valid and in_ready) and load it into the output registers, so that out_valid rises the following cycle (one-cycle latency).
REQ-021 SHALL, in FULL with out_ready=1 and a simultaneous accept, load the new instruction and stay in FULL with no bubble.
REQ-022 SHALL, in FULL with out_ready=1 and no accept, go to EMPTY.
REQ-023 SHALL hold all out_* signals stable while in FULL with out_ready=0.
REQ-024 SHALL, when a result with out_illegal=1 is consumed, go to HALT regardless of in_valid; no new instruction is accepted in that cycle.
REQ-025 SHALL, when flush=1, go to EMPTY next cycle from any state and drop any accept in that cycle; in_ready SHALL be 0 while flush=1.
REQ-026 SHALL increment dec_cnt by 1 on each consume (out_valid and out_ready and not flush), wrapping modulo 2^CNT_W.

Reset
REQ-027 SHALL, on rst=1, enter EMPTY immediately, without waiting for a clock edge, and clear out_inst, out_pc, out_imm, out_illegal and dec_cnt to 0 and out_op_imm to the I-format code.
REQ-028 SHALL discard any held result when reset is asserted mid-operation; the first instruction after reset is accepted in the first cycle after rst falls.

Structure
REQ-029 SHALL take the format codes (I=0, U=1, J=2, S=3, B=4), the opcode constants and the state encodings from the shared TYPES definitions.
REQ-030 SHALL instantiate decodeIMM as its single sub-module; the opcode classifier and the FSM stay local.

Verification
REQ-031 SHALL check: in_inst=0xFFF00093, pc=0x80000000 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_op_imm=0, out_illegal=0.
REQ-032 SHALL check: in_inst=0x123450B7 -> out_imm=0x12345000, out_op_imm=1; in_inst=0xFE000EE3 -> out_imm=0xFFFFFFFC, out_op_imm=4.
REQ-033 SHALL check: out_ready=0 for 3 cycles while FULL -> outputs stable and in_ready=0; then back-to-back stream with out_ready=1 -> one result per cycle and dec_cnt +1 per cycle.
REQ-034 SHALL check: in_inst=0x00000000 -> out_illegal=1; after it is consumed the state is HALT and in_ready=0; flush for 1 cycle -> EMPTY and in_ready=1.
REQ-035 SHALL check: rst asserted while FULL -> out_valid=0 and dec_cnt=0 without a clock edge; with CNT_W=4, 16 consumes -> dec_cnt wraps to 0.
